// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with a per-register pending scoreboard and issue stall.
// Defining RF_DEBUG_PORT_EN adds a side-effect-free debug read port and a write trace.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic              busy1,
   output logic              busy2,
   input  logic              issue_valid,
   input  logic              issue_we,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic              stall,
   input  logic              WB_RegWrite,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] writedata,
   output logic [ADDR_W:0]   pending_cnt
`ifdef RF_DEBUG_PORT_EN
   ,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              dbg_pending
`endif
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic [ADDR_W:0]   cnt;
   logic              wb_fire;
   logic              issue_fire;
   logic              hit1;
   logic              hit2;
   logic              cnt_inc;
   logic              cnt_dec;

   // A writeback in flight to a read register both forwards its data and resolves the hazard,
   // but only when bypass exists; pending[0] is never set, so address 0 is never busy.
   always_comb begin
      wb_fire    = WB_RegWrite && (wb_rd != '0);
      hit1       = wb_fire && (wb_rd == rs);
      hit2       = wb_fire && (wb_rd == rt);
      busy1      = pending[rs] && !(BYPASS && hit1);
      busy2      = pending[rt] && !(BYPASS && hit2);
      ReadData1  = (rs == '0) ? '0 : ((BYPASS && hit1) ? writedata : regs[rs]);
      ReadData2  = (rt == '0) ? '0 : ((BYPASS && hit2) ? writedata : regs[rt]);
      stall      = issue_valid && (busy1 || busy2);
      issue_fire = issue_valid && issue_we && (issue_rd != '0) && !stall;
      cnt_inc    = issue_fire && !pending[issue_rd];
      cnt_dec    = wb_fire && pending[wb_rd] && !(issue_fire && (issue_rd == wb_rd));
   end

   // The issue set is written after the writeback clear so a new producer wins on the same register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         pending <= '0;
         cnt     <= '0;
      end else begin
         if (wb_fire) begin
            regs[wb_rd]    <= writedata;
            pending[wb_rd] <= 1'b0;
         end
         if (issue_fire) begin
            pending[issue_rd] <= 1'b1;
         end
         cnt <= cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
      end
   end

   assign pending_cnt = cnt;

`ifdef RF_DEBUG_PORT_EN
   assign dbg_data    = (dbg_addr == '0) ? '0 : regs[dbg_addr];
   assign dbg_pending = pending[dbg_addr];

   always @(posedge clk) begin
      if (!rst && wb_fire) begin
         $display("reg:$%0d<=%h", wb_rd, writedata);
      end
   end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised bench for regfile_scoreboard: a BYPASS=1 and a BYPASS=0 instance share inputs
// and are both compared each cycle against an array-based reference model.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs, rt, issue_rd, wb_rd;
   logic        issue_valid, issue_we, WB_RegWrite;
   logic [31:0] writedata;

   logic [31:0] rd1 [2];
   logic [31:0] rd2 [2];
   logic        busy1 [2];
   logic        busy2 [2];
   logic        stall [2];
   logic [5:0]  cnt [2];

   int total = 0;
   int bad   = 0;

   logic [31:0] m_mem  [2][32];
   bit          m_pend [2][32];

`ifdef RF_DEBUG_PORT_EN
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data [2];
   logic        dbg_pend [2];
`endif

   always #5 clk = ~clk;

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt),
      .ReadData1(rd1[0]), .ReadData2(rd2[0]), .busy1(busy1[0]), .busy2(busy2[0]),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd), .stall(stall[0]),
      .WB_RegWrite(WB_RegWrite), .wb_rd(wb_rd), .writedata(writedata), .pending_cnt(cnt[0])
`ifdef RF_DEBUG_PORT_EN
      , .dbg_addr(dbg_addr), .dbg_data(dbg_data[0]), .dbg_pending(dbg_pend[0])
`endif
   );

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut1 (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt),
      .ReadData1(rd1[1]), .ReadData2(rd2[1]), .busy1(busy1[1]), .busy2(busy2[1]),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd), .stall(stall[1]),
      .WB_RegWrite(WB_RegWrite), .wb_rd(wb_rd), .writedata(writedata), .pending_cnt(cnt[1])
`ifdef RF_DEBUG_PORT_EN
      , .dbg_addr(dbg_addr), .dbg_data(dbg_data[1]), .dbg_pending(dbg_pend[1])
`endif
   );

   // Reference model: index b is the BYPASS setting of the instance it predicts.
   function automatic logic [31:0] exp_read(int b, logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (b == 1 && WB_RegWrite && wb_rd == a) return writedata;
      return m_mem[b][a];
   endfunction

   function automatic bit exp_busy(int b, logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      return m_pend[b][a] && !(b == 1 && WB_RegWrite && wb_rd == a);
   endfunction

   function automatic bit exp_stall(int b);
      return issue_valid && (exp_busy(b, rs) || exp_busy(b, rt));
   endfunction

   function automatic int exp_count(int b);
      int n = 0;
      for (int i = 0; i < 32; i++) n += m_pend[b][i] ? 1 : 0;
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check combinational outputs and state, then advance both model and DUT.
   task automatic applyStimulus(input bit r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                                input bit iv, input bit iwe, input logic [4:0] ird,
                                input bit we, input logic [4:0] wrd, input logic [31:0] wd);
      bit s [2];
      rst = r; rs = a_rs; rt = a_rt;
      issue_valid = iv; issue_we = iwe; issue_rd = ird;
      WB_RegWrite = we; wb_rd = wrd; writedata = wd;
`ifdef RF_DEBUG_PORT_EN
      dbg_addr = 5'($urandom_range(0, 31));
`endif
      #1;
      for (int b = 0; b < 2; b++) begin
         s[b] = exp_stall(b);
         checkOutput($sformatf("rd1_b%0d", b), 64'(rd1[b]), 64'(exp_read(b, rs)));
         checkOutput($sformatf("rd2_b%0d", b), 64'(rd2[b]), 64'(exp_read(b, rt)));
         checkOutput($sformatf("busy1_b%0d", b), 64'(busy1[b]), 64'(exp_busy(b, rs)));
         checkOutput($sformatf("busy2_b%0d", b), 64'(busy2[b]), 64'(exp_busy(b, rt)));
         checkOutput($sformatf("stall_b%0d", b), 64'(stall[b]), 64'(s[b]));
         checkOutput($sformatf("cnt_b%0d", b), 64'(cnt[b]), 64'(exp_count(b)));
`ifdef RF_DEBUG_PORT_EN
         checkOutput($sformatf("dbgdata_b%0d", b), 64'(dbg_data[b]),
                     64'((dbg_addr == 5'd0) ? 32'd0 : m_mem[b][dbg_addr]));
         checkOutput($sformatf("dbgpend_b%0d", b), 64'(dbg_pend[b]), 64'(m_pend[b][dbg_addr]));
`endif
      end
      @(posedge clk);
      for (int b = 0; b < 2; b++) begin
         if (r) begin
            for (int i = 0; i < 32; i++) begin
               m_mem[b][i]  = 32'd0;
               m_pend[b][i] = 1'b0;
            end
         end else begin
            if (we && wrd != 5'd0) begin
               m_mem[b][wrd]  = wd;
               m_pend[b][wrd] = 1'b0;
            end
            if (iv && iwe && ird != 5'd0 && !s[b]) m_pend[b][ird] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 32; i++) begin
            m_mem[b][i]  = 32'd0;
            m_pend[b][i] = 1'b0;
         end
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'd0);
      // Basic write/read, write to register 0
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF);
      applyStimulus(0, 3, 0, 0, 0, 0, 0, 0, 32'd0);
      applyStimulus(0, 0, 3, 0, 0, 0, 1, 0, 32'h12345678);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
      // Issue rd5, then a stalled issue of rd6 reading r5
      applyStimulus(0, 0, 0, 1, 1, 5, 0, 0, 32'd0);
      applyStimulus(0, 5, 0, 1, 1, 6, 0, 0, 32'd0);
      // Writeback to r5 while reading it: bypass hides the stall, no-bypass stalls one more cycle
      applyStimulus(0, 5, 0, 1, 0, 0, 1, 5, 32'hA5A5A5A5);
      applyStimulus(0, 5, 0, 1, 0, 0, 0, 0, 32'd0);
      // Same-register issue+WB keeps the bit; different registers net zero
      applyStimulus(0, 0, 0, 1, 1, 7, 0, 0, 32'd0);
      applyStimulus(0, 0, 0, 1, 1, 7, 1, 7, 32'h11111111);
      applyStimulus(0, 0, 0, 1, 1, 9, 0, 0, 32'd0);
      applyStimulus(0, 0, 0, 1, 1, 8, 1, 9, 32'h22222222);
      applyStimulus(0, 0, 0, 1, 1, 7, 0, 0, 32'd0);
      // Pend 1..4 then reset together with a writeback
      for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 1, 1, 5'(i), 0, 0, 32'd0);
      applyStimulus(1, 1, 2, 1, 1, 10, 1, 2, 32'hCAFEF00D);
      applyStimulus(0, 1, 2, 0, 0, 0, 0, 0, 32'd0);
      applyStimulus(0, 3, 8, 0, 0, 0, 0, 0, 32'd0);
      // Random traffic concentrated on a few registers to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] lim;
         lim = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
         applyStimulus(($urandom_range(0, 199) == 0),
                       5'($urandom_range(0, lim)), 5'($urandom_range(0, lim)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                       5'($urandom_range(0, lim)),
                       1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, lim)),
                       32'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
